// File: rtl/bika_neuron_array.sv
// bika_neuron_array: NUM_CH threshold neurons accumulating saturated +/-1 votes over framed activation beats
module bika_neuron_array #(
  parameter int DATA_W = 8,
  parameter int ACC_W = 16,
  parameter int NUM_CH = 4,
  parameter int LEN_W = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic signed [DATA_W-1:0] activ_in,
  input  logic [NUM_CH*DATA_W-1:0] threshold_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LEN_W-1:0]         in_length,
  input  logic                     out_mode,
  input  logic                     soft_clr,
  output logic [NUM_CH*ACC_W-1:0]  out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sat
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
  localparam logic signed [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};
  state_t state, state_nx;
  logic rdy_en, mode, s1_v, s1_last, take, last_c, hs;
  logic [LEN_W-1:0] len, cnt, len_c;
  logic [NUM_CH-1:0] s1_p, p_c, clamp;
  logic signed [ACC_W-1:0] acc [NUM_CH];
  logic signed [ACC_W-1:0] acc_nx [NUM_CH];
  logic signed [ACC_W-1:0] out_r [NUM_CH];
  assign in_ready = rdy_en && (state == IDLE || state == ACCUM);
  assign take = in_valid && in_ready && !soft_clr;
  assign hs = state == HOLD && out_ready;
  assign len_c = in_length == '0 ? LEN_W'(1) : in_length;
  assign last_c = state == IDLE ? len_c == LEN_W'(1) : (cnt + LEN_W'(1)) == len;
  always_comb begin
    state_nx = state == IDLE  ? (take ? (last_c ? DRAIN : ACCUM) : IDLE) :
               state == ACCUM ? (take && last_c ? DRAIN : ACCUM) :
               state == DRAIN ? (s1_last ? HOLD : DRAIN) :
                                (out_ready ? IDLE : HOLD);
  end
  always_comb begin
    p_c = '0;
    clamp = '0;
    acc_nx = acc;
    for (int c = 0; c < NUM_CH; c++) begin
      p_c[c] = activ_in >= $signed(threshold_in[c*DATA_W +: DATA_W]);
      clamp[c] = s1_v && (s1_p[c] ? acc[c] == MAX : acc[c] == MIN);
      acc_nx[c] = (!s1_v || clamp[c]) ? acc[c] : s1_p[c] ? acc[c] + ACC_W'(1) : acc[c] - ACC_W'(1);
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      rdy_en <= 1'b0;
      mode <= 1'b0;
      len <= '0;
      cnt <= '0;
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      s1_p <= '0;
      out_valid <= 1'b0;
      out_sat <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        out_r[c] <= '0;
      end
    end else begin
      rdy_en <= 1'b1;
      if (soft_clr) begin
        state <= IDLE;
        cnt <= '0;
        s1_v <= 1'b0;
        s1_last <= 1'b0;
        s1_p <= '0;
        out_valid <= 1'b0;
        out_sat <= 1'b0;
        for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
      end else begin
        state <= state_nx;
        s1_v <= take;
        s1_last <= take && last_c;
        if (take) s1_p <= p_c;
        if (take) cnt <= state == IDLE ? LEN_W'(1) : cnt + LEN_W'(1);
        if (take && state == IDLE) begin
          len <= len_c;
          mode <= out_mode;
        end
        out_sat <= hs ? 1'b0 : out_sat | (|clamp);
        for (int c = 0; c < NUM_CH; c++) acc[c] <= hs ? '0 : acc_nx[c];
        // the final product is folded in on the way into HOLD so out_valid lands two cycles after the last beat
        if (state == DRAIN && s1_last) begin
          out_valid <= 1'b1;
          for (int c = 0; c < NUM_CH; c++)
            out_r[c] <= !mode ? acc_nx[c] : acc_nx[c][ACC_W-1] ? '1 : ACC_W'(1);
        end else if (hs) begin
          out_valid <= 1'b0;
        end
      end
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign out[c*ACC_W +: ACC_W] = out_r[c];
  end
endmodule

// File: tb/tb_bika_neuron_array.sv
// tb_bika_neuron_array: random and directed frames checked against a vote-counting model at two accumulator widths
module tb_bika_neuron_array;
  localparam int N = 4;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic signed [7:0] activ_in;
  logic [N*8-1:0] threshold_in;
  logic in_valid, out_mode, soft_clr, out_ready;
  logic [15:0] in_length;
  logic rdy_a, rdy_b, ov_a, ov_b, sat_a, sat_b;
  logic [N*16-1:0] out_a;
  logic [N*4-1:0] out_b;
  int checks = 0;
  int errors = 0;
  int th [N];
  int act_q [$];
  always #5 sys_clk = ~sys_clk;
  bika_neuron_array #(.DATA_W(8), .ACC_W(16), .NUM_CH(N), .LEN_W(16)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .activ_in(activ_in), .threshold_in(threshold_in),
    .in_valid(in_valid), .in_ready(rdy_a), .in_length(in_length), .out_mode(out_mode),
    .soft_clr(soft_clr), .out(out_a), .out_valid(ov_a), .out_ready(out_ready), .out_sat(sat_a));
  bika_neuron_array #(.DATA_W(8), .ACC_W(4), .NUM_CH(N), .LEN_W(16)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .activ_in(activ_in), .threshold_in(threshold_in),
    .in_valid(in_valid), .in_ready(rdy_b), .in_length(in_length), .out_mode(out_mode),
    .soft_clr(soft_clr), .out(out_b), .out_valid(ov_b), .out_ready(out_ready), .out_sat(sat_b));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // each beat is a +1/-1 vote per channel; the running sum is clamped to the w-bit signed range
  function automatic void model(input int w, input bit mode, output logic [63:0] o, output bit sat);
    int hi, lo, s, st;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    o = '0;
    sat = 1'b0;
    for (int c = 0; c < N; c++) begin
      s = 0;
      foreach (act_q[i]) begin
        st = act_q[i] >= th[c] ? 1 : -1;
        if (s + st > hi || s + st < lo) sat = 1'b1;
        else s += st;
      end
      if (mode) s = s >= 0 ? 1 : -1;
      o |= (64'(s) & ((64'd1 << w) - 1)) << (c * w);
    end
  endfunction
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic set_th();
    for (int c = 0; c < N; c++) threshold_in[c*8 +: 8] = 8'(th[c]);
  endtask
  task automatic rand_acts(input int n);
    act_q.delete();
    for (int i = 0; i < n; i++) act_q.push_back(int'($urandom_range(0, 255)) - 128);
  endtask
  task automatic rand_th();
    for (int c = 0; c < N; c++) th[c] = int'($urandom_range(0, 255)) - 128;
    set_th();
  endtask
  task automatic run_frame(input int len, input bit mode, input int gap, input int hold);
    int eff;
    logic [63:0] ea, eb;
    bit sa, sb;
    eff = len == 0 ? 1 : len;
    model(16, mode, ea, sa);
    model(4, mode, eb, sb);
    for (int i = 0; i < eff; i++) begin
      if (i > 0) repeat (gap) begin
        in_valid = 1'b0;
        activ_in = 8'($urandom);
        in_length = 16'($urandom);
        out_mode = 1'($urandom);
        step();
      end
      in_valid = 1'b1;
      activ_in = 8'(act_q[i]);
      in_length = i == 0 ? 16'(len) : 16'($urandom);
      out_mode = i == 0 ? mode : 1'($urandom);
      chk("in_ready", {rdy_a, rdy_b}, 2'b11);
      step();
    end
    in_valid = 1'b0;
    chk("drain_valid", {ov_a, ov_b}, 2'b00);
    step();
    chk("out_valid", {ov_a, ov_b}, 2'b11);
    chk("out_a", out_a, ea);
    chk("out_b", out_b, eb);
    chk("out_sat", {sat_a, sat_b}, {sa, sb});
    chk("busy_ready", {rdy_a, rdy_b}, 2'b00);
    repeat (hold) begin
      step();
      chk("hold_out_a", out_a, ea);
      chk("hold_out_b", out_b, eb);
      chk("hold_flags", {ov_a, ov_b, sat_a, sat_b, rdy_a, rdy_b}, {2'b11, sa, sb, 2'b00});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_flags", {ov_a, ov_b, sat_a, sat_b}, 4'b0000);
    chk("post_hs_ready", {rdy_a, rdy_b}, 2'b11);
  endtask
  initial begin
    logic [63:0] keep_a, keep_b;
    int len;
    in_valid = 1'b0;
    activ_in = '0;
    threshold_in = '0;
    in_length = '0;
    out_mode = 1'b0;
    soft_clr = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    chk("rst_outs", {out_a, out_b}, '0);
    chk("rst_flags", {ov_a, ov_b, sat_a, sat_b, rdy_a, rdy_b}, '0);
    sys_rst_n = 1'b1;
    step();
    chk("ready_after_rst", {rdy_a, rdy_b}, 2'b11);
    th = '{0, 10, -5, 127};
    set_th();
    act_q = '{5, 10, -128};
    run_frame(3, 1'b0, 0, 0);
    run_frame(3, 1'b1, 0, 0);
    th = '{0, 0, 0, 0};
    set_th();
    act_q = '{0, 0, -1, -1};
    run_frame(4, 1'b1, 0, 0);
    th = '{-128, -128, -128, -128};
    set_th();
    rand_acts(10);
    run_frame(10, 1'b0, 0, 0);
    rand_acts(2);
    run_frame(2, 1'b0, 0, 0);
    rand_th();
    rand_acts(4);
    run_frame(4, 1'b0, 0, 5);
    rand_acts(1);
    run_frame(0, 1'b1, 0, 0);
    run_frame(1, 1'b0, 0, 0);
    rand_acts(5);
    run_frame(5, 1'b0, 0, 0);
    run_frame(5, 1'b0, 3, 0);
    keep_a = out_a;
    keep_b = out_b;
    rand_acts(5);
    in_length = 16'd5;
    out_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      activ_in = 8'(act_q[i]);
      step();
    end
    soft_clr = 1'b1;
    activ_in = 8'sd127;
    step();
    soft_clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_flags", {ov_a, ov_b, sat_a, sat_b}, 4'b0000);
    chk("clr_ready", {rdy_a, rdy_b}, 2'b11);
    chk("clr_keep_a", out_a, keep_a);
    chk("clr_keep_b", out_b, keep_b);
    repeat (3) begin
      step();
      chk("clr_no_valid", {ov_a, ov_b}, 2'b00);
    end
    rand_acts(5);
    run_frame(5, 1'b0, 0, 0);
    for (int f = 0; f < 25; f++) begin
      rand_th();
      len = $urandom_range(0, 12);
      rand_acts(len == 0 ? 1 : len);
      run_frame(len, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    rand_acts(4);
    in_length = 16'd4;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      activ_in = 8'(act_q[i]);
      step();
    end
    in_valid = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_outs", {out_a, out_b}, '0);
    chk("arst_flags", {ov_a, ov_b, sat_a, sat_b, rdy_a, rdy_b}, '0);
    step();
    sys_rst_n = 1'b1;
    step();
    rand_th();
    rand_acts(6);
    run_frame(6, 1'b0, 1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
